// File: rtl/systolic_row_feeder.sv
// Skews operand columns into the diagonal wavefront a systolic PE grid
// expects. Lane k is delayed k cycles relative to lane 0, tiles of
// depth_p beats are counted, and done_o pulses once the last beat has
// drained out of the deepest lane.
module systolic_row_feeder #(
    parameter int width_p        = 8,
    parameter int array_height_p = 2,
    parameter int depth_p        = 2
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              en_i,
    input  logic                              flush_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic [array_height_p*width_p-1:0] data_i,
    output logic [array_height_p-1:0]         row_valid_o,
    output logic [array_height_p*width_p-1:0] row_data_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int BW = $clog2(depth_p + 1);
    localparam int DW = $clog2(array_height_p + 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(depth_p - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(array_height_p - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2} state_t;

    state_t        r_state;
    logic [BW-1:0] r_beat_cnt;
    logic [DW-1:0] r_drain_cnt;
    logic          r_done;
    logic          w_acc;

    // ready depends only on state and control inputs, never on valid_i;
    // reset_i gates it so ready stays low while reset is held.
    assign ready_o = reset_i && en_i && !flush_i &&
                     (r_state == IDLE || r_state == LOAD);
    assign w_acc   = valid_i && ready_o;
    assign busy_o  = (r_state == LOAD) || (r_state == DRAIN);
    assign done_o  = r_done;

    // Tile sequencing: count beats in LOAD, count skew drain in DRAIN.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else if (en_i) begin
            r_done <= 1'b0;
            if (flush_i) begin
                r_state     <= IDLE;
                r_beat_cnt  <= '0;
                r_drain_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_acc) begin
                            if (depth_p == 1) begin
                                r_state    <= DRAIN;
                                r_beat_cnt <= '0;
                            end else begin
                                r_state    <= LOAD;
                                r_beat_cnt <= BW'(1);
                            end
                        end
                    end
                    LOAD: begin
                        if (w_acc) begin
                            if (r_beat_cnt == LAST_BEAT) begin
                                r_state    <= DRAIN;
                                r_beat_cnt <= '0;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + BW'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        // The last beat is visible on the deepest lane after
                        // array_height_p-1 drain edges; leave one edge later.
                        if (r_drain_cnt == LAST_DRAIN) begin
                            r_state     <= IDLE;
                            r_drain_cnt <= '0;
                            r_done      <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + DW'(1);
                        end
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_beat_cnt  <= '0;
                        r_drain_cnt <= '0;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < array_height_p; k++) begin : g_lane
        logic [k:0]         r_v;
        logic [width_p-1:0] r_d [0:k];

        // Lane k shift chain, k+1 stages; non-accept cycles inject zeros.
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                r_v <= '0;
                for (int s = 0; s <= k; s++) r_d[s] <= '0;
            end else if (en_i) begin
                if (flush_i) begin
                    r_v <= '0;
                    for (int s = 0; s <= k; s++) r_d[s] <= '0;
                end else begin
                    r_v[0] <= w_acc;
                    r_d[0] <= w_acc ? data_i[k*width_p +: width_p] : '0;
                    for (int s = 1; s <= k; s++) begin
                        r_v[s] <= r_v[s-1];
                        r_d[s] <= r_d[s-1];
                    end
                end
            end
        end

        assign row_valid_o[k]                   = r_v[k];
        assign row_data_o[k*width_p +: width_p] = r_d[k];
    end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Directed bench for systolic_row_feeder at default parameters
// (2 lanes, 8-bit elements, 2 beats per tile).
module tb_systolic_row_feeder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        en_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_i;
    logic [1:0]  row_valid_o;
    logic [15:0] row_data_o;
    logic        busy_o;
    logic        done_o;

    int n_chk = 0;
    int n_err = 0;

    systolic_row_feeder #(.width_p(8), .array_height_p(2), .depth_p(2)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .row_valid_o (row_valid_o),
        .row_data_o  (row_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Check the lane outputs and done together.
    task automatic lanes(input string tag, input logic [1:0] rv, input logic [15:0] rd,
                         input logic dn);
        chk({tag, ".rv"},   32'(row_valid_o), 32'(rv));
        chk({tag, ".rd"},   32'(row_data_o),  32'(rd));
        chk({tag, ".done"}, 32'(done_o),      32'(dn));
    endtask

    initial begin
        reset_i = 1'b0; en_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; data_i = '0;

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            lanes("rst", 2'b00, 16'h0000, 1'b0);
            chk("rst.ready", 32'(ready_o), 32'd0);
            chk("rst.busy",  32'(busy_o),  32'd0);
        end
        reset_i = 1'b1;
        #1;
        chk("rel.ready", 32'(ready_o), 32'd1);
        chk("rel.rv",    32'(row_valid_o), 32'd0);

        // Skew timing, then finish the tile
        valid_i = 1'b1; data_i = 16'h2211;
        step();
        lanes("skew.e0", 2'b01, 16'h0011, 1'b0);
        chk("skew.e0.ready", 32'(ready_o), 32'd1);
        chk("skew.e0.busy",  32'(busy_o),  32'd1);
        valid_i = 1'b0;
        step();
        lanes("skew.e1", 2'b10, 16'h2200, 1'b0);
        valid_i = 1'b1; data_i = 16'h4433;
        step();
        lanes("skew.e2", 2'b01, 16'h0033, 1'b0);
        chk("skew.e2.ready", 32'(ready_o), 32'd0);
        valid_i = 1'b0;
        step();
        lanes("skew.e3", 2'b10, 16'h4400, 1'b0);
        step();
        lanes("skew.e4", 2'b00, 16'h0000, 1'b1);
        chk("skew.e4.busy", 32'(busy_o), 32'd0);
        step();
        chk("skew.e5.done", 32'(done_o), 32'd0);

        // Full back-to-back tile
        valid_i = 1'b1; data_i = 16'h1211;
        step();
        lanes("tile.e0", 2'b01, 16'h0011, 1'b0);
        chk("tile.e0.ready", 32'(ready_o), 32'd1);
        data_i = 16'h2221;
        step();
        lanes("tile.e1", 2'b11, 16'h1221, 1'b0);
        chk("tile.e1.ready", 32'(ready_o), 32'd0);
        chk("tile.e1.busy",  32'(busy_o),  32'd1);
        valid_i = 1'b0;
        step();
        lanes("tile.e2", 2'b10, 16'h2200, 1'b0);
        step();
        lanes("tile.e3", 2'b00, 16'h0000, 1'b1);
        chk("tile.e3.busy",  32'(busy_o),  32'd0);
        chk("tile.e3.ready", 32'(ready_o), 32'd1);
        step();
        chk("tile.e4.done", 32'(done_o), 32'd0);

        // Bubble then 3-cycle stall mid-drain
        valid_i = 1'b1; data_i = 16'h3231;
        step();
        lanes("bub.e0", 2'b01, 16'h0031, 1'b0);
        valid_i = 1'b0;
        step();
        lanes("bub.e1", 2'b10, 16'h3200, 1'b0);
        valid_i = 1'b1; data_i = 16'h4241;
        step();
        lanes("bub.e2", 2'b01, 16'h0041, 1'b0);
        valid_i = 1'b0;
        step();
        lanes("bub.e3", 2'b10, 16'h4200, 1'b0);
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            lanes("stall", 2'b10, 16'h4200, 1'b0);
            chk("stall.busy", 32'(busy_o), 32'd1);
        end
        en_i = 1'b1;
        step();
        lanes("bub.e7", 2'b00, 16'h0000, 1'b1);
        step();
        chk("bub.e8.done", 32'(done_o), 32'd0);

        // Flush mid-LOAD with a simultaneous valid beat
        valid_i = 1'b1; data_i = 16'h5251;
        step();
        lanes("fl.e0", 2'b01, 16'h0051, 1'b0);
        data_i = 16'h6261; flush_i = 1'b1;
        #1;
        chk("fl.ready", 32'(ready_o), 32'd0);
        step();
        lanes("fl.e1", 2'b00, 16'h0000, 1'b0);
        chk("fl.e1.busy", 32'(busy_o), 32'd0);
        flush_i = 1'b0; valid_i = 1'b0;
        step();
        lanes("fl.e2", 2'b00, 16'h0000, 1'b0);
        chk("fl.e2.ready", 32'(ready_o), 32'd1);

        // Async reset mid-DRAIN
        valid_i = 1'b1; data_i = 16'h7271;
        step();
        data_i = 16'h8281;
        step();
        lanes("ar.e1", 2'b11, 16'h7281, 1'b0);
        valid_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        lanes("ar.low", 2'b00, 16'h0000, 1'b0);
        chk("ar.low.busy",  32'(busy_o),  32'd0);
        chk("ar.low.ready", 32'(ready_o), 32'd0);
        #2 reset_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            lanes("ar.post", 2'b00, 16'h0000, 1'b0);
            chk("ar.post.busy", 32'(busy_o), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
